// File: rtl/pulse_pacer_if.sv
// Signal bundle for the pulse pacer: event/clear strobes in, paced pulse and status out.
interface pulse_pacer_if #(
  parameter int CNT_W = 8
);
  logic             event_i;
  logic             clr_ovf_i;
  logic             pulse_o;
  logic [CNT_W-1:0] pending_o;
  logic             busy_o;
  logic             overflow_o;

  modport master (
    output event_i, clr_ovf_i,
    input  pulse_o, pending_o, busy_o, overflow_o
  );

  modport slave (
    input  event_i, clr_ovf_i,
    output pulse_o, pending_o, busy_o, overflow_o
  );
endinterface

// File: rtl/pulse_pacer.sv
// Queues bursty single-cycle events and re-emits them as single-cycle pulses
// spaced at least GAP cycles apart, ahead of a toggle-based pulse synchronizer.
module pulse_pacer #(
  parameter int CNT_W = 8,
  parameter int GAP   = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  pulse_pacer_if.slave bus
);
  // Timer holds GAP-2 at most: the issue cycle and the expiring cycle are not counted.
  localparam int TW = (GAP > 2) ? $clog2(GAP - 1) : 1;

  typedef enum logic {S_IDLE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pulse_q, ovf_q, ovf_d, busy_q, busy_d;
  logic             issue, drop, acc;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;

    issue = (state_q == S_IDLE) && ((pending_q != '0) || bus.event_i);
    drop  = bus.event_i && (pending_q == '1) && !issue;
    acc   = bus.event_i && !drop;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_GAP;
          timer_d = TW'(GAP - 2);
        end
      end
      S_GAP: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // An event passing straight through (acc & issue) leaves the backlog unchanged.
    if (acc && !issue)      pending_d = pending_q + 1'b1;
    else if (!acc && issue) pending_d = pending_q - 1'b1;

    if (drop)               ovf_d = 1'b1;
    else if (bus.clr_ovf_i) ovf_d = 1'b0;

    busy_d = (pending_d != '0) || (state_d == S_GAP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      pulse_q   <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      pulse_q   <= issue;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.pulse_o    = pulse_q;
  assign bus.pending_o  = pending_q;
  assign bus.busy_o     = busy_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench for pulse_pacer: a time-since-last-issue model predicts pulse cycles,
// backlog, busy and overflow; directed checks cover reset, burst, saturation and clear.
module tb_pulse_pacer;
  localparam int CNT_W = 3;
  localparam int GAP   = 4;
  localparam int MAX   = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_pacer_if #(.CNT_W(CNT_W)) bus ();

  pulse_pacer #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = -1;
  int exp_q[$];
  int m_pend = 0;
  int m_last = -1000;
  bit m_ovf = 1'b0;
  bit chk_en = 1'b0;
  int npulse = 0;
  int peak = 0;
  int pt[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic sb_check();
    bit exp_pulse;
    int d;
    exp_pulse = (exp_q.size() > 0) && (exp_q[0] == cyc);
    check("pulse", 32'(bus.pulse_o), 32'(exp_pulse));
    if (exp_pulse) void'(exp_q.pop_front());
    check("pending", 32'(bus.pending_o), 32'(m_pend));
    d = cyc - m_last;
    check("busy", 32'(bus.busy_o), 32'((m_pend != 0) || (d >= 1 && d <= GAP - 1)));
    check("overflow", 32'(bus.overflow_o), 32'(m_ovf));
    if (bus.pulse_o === 1'b1) npulse++;
    if (int'(bus.pending_o) > peak) peak = int'(bus.pending_o);
  endtask

  task automatic tick(input bit ev, input bit clr, input bit r);
    bit issue, drop;
    @(negedge clk);
    cyc++;
    if (chk_en) sb_check();
    bus.event_i   = ev;
    bus.clr_ovf_i = clr;
    rst           = r;
    if (r) begin
      m_pend = 0;
      m_ovf  = 1'b0;
      m_last = -1000;
    end else begin
      issue = (cyc - m_last >= GAP) && (m_pend > 0 || ev);
      if (issue) begin
        exp_q.push_back(cyc + 1);
        m_last = cyc;
      end
      drop = ev && (m_pend == MAX) && !issue;
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (ev && !drop) m_pend++;
      if (issue)       m_pend--;
    end
  endtask

  initial begin
    int exp3[5];
    exp3 = '{11, 15, 19, 23, 27};
    bus.event_i   = 1'b0;
    bus.clr_ovf_i = 1'b0;

    // Reset held with events asserted
    tick(1, 0, 1);
    chk_en = 1'b1;
    tick(1, 0, 1);
    tick(1, 0, 1);
    npulse = 0;
    for (int r = 0; r < 10; r++) tick(0, 0, 0);
    check("reset_no_pulse", 32'(npulse), 32'd0);

    // Single event
    npulse = 0;
    for (int r = 0; r < 30; r++) begin
      tick(r == 10, 0, 0);
      if (r == 11) check("single_pulse_11", 32'(bus.pulse_o), 32'd1);
      if (r == 12) check("single_busy_gap", 32'(bus.busy_o), 32'd1);
      if (r == 14) check("single_busy_done", 32'(bus.busy_o), 32'd0);
    end
    check("single_count", 32'(npulse), 32'd1);

    // Burst of five
    npulse = 0; peak = 0; pt.delete();
    for (int r = 0; r < 40; r++) begin
      tick(r >= 10 && r <= 14, 0, 0);
      if (bus.pulse_o === 1'b1) pt.push_back(r);
    end
    check("burst_count", 32'(pt.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("burst_time", 32'(pt[i]), 32'(exp3[i]));
    check("burst_peak", 32'(peak), 32'd3);
    check("burst_end_pending", 32'(bus.pending_o), 32'd0);

    // Saturation
    tick(0, 0, 1);
    npulse = 0; peak = 0; pt.delete();
    for (int r = 0; r < 60; r++) begin
      tick(r <= 11, 0, 0);
      if (bus.pulse_o === 1'b1) pt.push_back(r);
      if (r == 10) check("sat_ovf_10", 32'(bus.overflow_o), 32'd0);
      if (r == 11) check("sat_ovf_11", 32'(bus.overflow_o), 32'd1);
    end
    check("sat_count", 32'(npulse), 32'd10);
    check("sat_peak", 32'(peak), 32'(MAX));
    for (int i = 1; i < pt.size(); i++) check("sat_spacing", 32'(pt[i] - pt[i-1]), 32'(GAP));

    // Overflow clear coinciding with a drop, then alone
    tick(0, 0, 1);
    for (int r = 0; r < 50; r++) begin
      tick(r <= 10, r == 10 || r == 11, 0);
      if (r == 11) check("clr_set_wins", 32'(bus.overflow_o), 32'd1);
      if (r == 12) check("clr_alone", 32'(bus.overflow_o), 32'd0);
    end

    // Reset mid-backlog
    tick(0, 0, 1);
    for (int r = 0; r < 40; r++) begin
      tick(r <= 5, 0, r == 6);
      if (r == 6) begin
        check("midrst_pending_4", 32'(bus.pending_o), 32'd4);
        npulse = 0;
      end
      if (r == 7) begin
        check("midrst_pending_0", 32'(bus.pending_o), 32'd0);
        check("midrst_busy_0", 32'(bus.busy_o), 32'd0);
      end
    end
    check("midrst_no_pulse", 32'(npulse), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
